// File: rtl/bitbakery_pkg.sv
// Shared state encoding and width helpers for the BitBakery session sequencer.
package bitbakery_pkg;

    localparam int ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        ST_INICIAL    = 4'd0,
        ST_PREPARACAO = 4'd1,
        ST_INTERVALO  = 4'd2,
        ST_START      = 4'd3,
        ST_EXECUCAO   = 4'd4,
        ST_REGISTRA   = 4'd5,
        ST_FIM        = 4'd6
    } state_t;

    function automatic int sel_width(int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bitbakery_session_sequencer_if.sv
// Board-side and minigame-side signals of the session sequencer.
interface bitbakery_session_sequencer_if #(
    parameter int N_GAMES = 3,
    parameter int ROUNDS  = 3,
    parameter int SCORE_W = 3
);
    import bitbakery_pkg::*;

    localparam int SEL_W   = sel_width(N_GAMES);
    localparam int TOTAL_W = SCORE_W + $clog2(ROUNDS + 1);

    logic                       iniciar;
    logic                       dificuldade;
    logic [SEL_W-1:0]           minigame;
    logic [N_GAMES-1:0]         pronto_vec;
    logic [N_GAMES*SCORE_W-1:0] pontuacao_vec;

    logic [N_GAMES-1:0]         jogar_vec;
    logic [SEL_W-1:0]           game_sel;
    logic                       dificuldade_lat;
    logic [ESTADO_W-1:0]        estado;
    logic [3:0]                 rodada;
    logic [TOTAL_W-1:0]         total_score;
    logic                       sessao_fim;
    logic                       timeout;

    modport master (
        output iniciar, dificuldade, minigame, pronto_vec, pontuacao_vec,
        input  jogar_vec, game_sel, dificuldade_lat, estado, rodada,
               total_score, sessao_fim, timeout
    );

    modport slave (
        input  iniciar, dificuldade, minigame, pronto_vec, pontuacao_vec,
        output jogar_vec, game_sel, dificuldade_lat, estado, rodada,
               total_score, sessao_fim, timeout
    );

endinterface

// File: rtl/bitbakery_phase_timer.sv
// Loadable up-counter with synchronous clear and terminal-count compare.
module bitbakery_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)       count_d = '0;
        else if (load_i) count_d = load_val_i;
        else if (en_i)   count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/bitbakery_session_sequencer.sv
// Multi-round BitBakery session controller. Define AUTO_ADVANCE_EN to chain
// rounds straight into INTERVALO with the next game selected automatically.
module bitbakery_session_sequencer
    import bitbakery_pkg::*;
#(
    parameter int N_GAMES         = 3,
    parameter int ROUNDS          = 3,
    parameter int INTERVAL_CYCLES = 2000,
    parameter int TIMEOUT_CYCLES  = 60000,
    parameter int SCORE_W         = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    bitbakery_session_sequencer_if.slave  bus
);

    localparam int SEL_W   = sel_width(N_GAMES);
    localparam int TOTAL_W = SCORE_W + $clog2(ROUNDS + 1);
    localparam int TMR_W   = $clog2(max2(INTERVAL_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [SEL_W:0]     NG_L     = (SEL_W + 1)'(N_GAMES);
    localparam logic [3:0]         ROUNDS_L = 4'(ROUNDS);
    localparam logic [TMR_W-1:0]   INT_TERM = TMR_W'(INTERVAL_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TO_TERM  = TMR_W'(TIMEOUT_CYCLES - 1);
`ifdef AUTO_ADVANCE_EN
    localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(N_GAMES - 1);
`endif

    state_t               state_q;
    logic                 ini_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 dif_q;
    logic [3:0]           rodada_q;
    logic [TOTAL_W-1:0]   total_q;
    logic                 timeout_q;
    logic                 scored_q;
    logic [N_GAMES-1:0]   jogar_q;

    logic                 ini_p;
    logic                 sel_valid;
    logic                 pronto_sel;
    logic [SCORE_W-1:0]   score_sel;
    logic                 tmr_en;
    logic [TMR_W-1:0]     tmr_term;
    logic                 tmr_tc;

    assign ini_p      = bus.iniciar & ~ini_q;
    assign sel_valid  = ({1'b0, bus.minigame} < NG_L);
    assign pronto_sel = bus.pronto_vec[sel_q];
    assign score_sel  = bus.pontuacao_vec[int'(sel_q)*SCORE_W +: SCORE_W];

    // One timer serves both phases; holding it cleared elsewhere gives a fresh count on entry.
    always_comb begin
        tmr_en   = 1'b0;
        tmr_term = '0;
        case (state_q)
            ST_INTERVALO: begin tmr_en = 1'b1; tmr_term = INT_TERM; end
            ST_EXECUCAO:  begin tmr_en = 1'b1; tmr_term = TO_TERM;  end
            default: ;
        endcase
    end

    bitbakery_phase_timer #(.WIDTH(TMR_W)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (~tmr_en),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .term_i     (tmr_term),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INICIAL;
            ini_q     <= 1'b1;
            sel_q     <= '0;
            dif_q     <= 1'b0;
            rodada_q  <= '0;
            total_q   <= '0;
            timeout_q <= 1'b0;
            scored_q  <= 1'b0;
            jogar_q   <= '0;
        end else begin
            ini_q   <= bus.iniciar;
            jogar_q <= '0;
            case (state_q)
                ST_INICIAL, ST_FIM: begin
                    if (ini_p) begin
                        state_q   <= ST_PREPARACAO;
                        total_q   <= '0;
                        timeout_q <= 1'b0;
                        rodada_q  <= 4'd1;
                    end
                end
                ST_PREPARACAO: begin
                    sel_q <= bus.minigame;
                    dif_q <= bus.dificuldade;
                    if (ini_p && sel_valid) state_q <= ST_INTERVALO;
                end
                ST_INTERVALO: begin
                    if (tmr_tc) begin
                        state_q <= ST_START;
                        jogar_q <= N_GAMES'(1) << sel_q;
                    end
                end
                ST_START: state_q <= ST_EXECUCAO;
                ST_EXECUCAO: begin
                    // pronto is checked first so it wins over a coincident expiry
                    if (pronto_sel) begin
                        state_q  <= ST_REGISTRA;
                        scored_q <= 1'b1;
                    end else if (tmr_tc) begin
                        state_q   <= ST_REGISTRA;
                        scored_q  <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                ST_REGISTRA: begin
                    if (scored_q) total_q <= total_q + TOTAL_W'(score_sel);
                    if (rodada_q == ROUNDS_L) begin
                        state_q <= ST_FIM;
                    end else begin
                        rodada_q <= rodada_q + 4'd1;
`ifdef AUTO_ADVANCE_EN
                        state_q <= ST_INTERVALO;
                        sel_q   <= (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
`else
                        state_q <= ST_PREPARACAO;
`endif
                    end
                end
                default: state_q <= ST_INICIAL;
            endcase
        end
    end

    assign bus.jogar_vec       = jogar_q;
    assign bus.game_sel        = sel_q;
    assign bus.dificuldade_lat = dif_q;
    assign bus.estado          = state_q;
    assign bus.rodada          = rodada_q;
    assign bus.total_score     = total_q;
    assign bus.sessao_fim      = (state_q == ST_FIM);
    assign bus.timeout         = timeout_q;

endmodule
